// File: rtl/alu_pkg.sv
// Shared definitions for the FIR tap arithmetic unit: default widths and opcodes.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 16;
  localparam int unsigned ALU_RES_W  = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MAC = 2'b11;

endpackage

// File: rtl/alu_mult.sv
// Combinational signed DATA_W x DATA_W multiplier with a full-precision product.
// Kept separate so a hardened or pipelined multiplier can replace it.
// Ports:
//   a_i    - signed multiplicand
//   b_i    - signed multiplier
//   prod_o - signed 2*DATA_W product (combinational)
module alu_mult
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W
) (
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [2*DATA_W-1:0] prod_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  // Sign-extend both operands to the product width so the multiply is exact.
  assign prod_o = PROD_W'($signed(a_i)) * PROD_W'($signed(b_i));

endmodule

// File: rtl/alu.sv
// Two-stage pipelined signed arithmetic unit (add / mul / sub / MAC) for the FIR core.
// Stage 1 registers operands and opcode; stage 2 computes and registers the result.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   op_sel - 00 add, 01 multiply, 10 subtract, 11 multiply-accumulate
//   a, b   - signed DATA_W operands
//   result - signed RES_W registered result (also the MAC accumulator)
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned RES_W  = ALU_RES_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        op_sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [RES_W-1:0]  result
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [1:0]        op_q;
  logic [RES_W-1:0]  result_q;
  logic [RES_W-1:0]  result_d;

  logic [PROD_W-1:0] prod;
  logic [RES_W-1:0]  a_ext;
  logic [RES_W-1:0]  b_ext;
  logic [RES_W-1:0]  prod_ext;

  // Stage 1: operand and opcode capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_ADD;
    end else begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op_sel;
    end
  end

  alu_mult #(
    .DATA_W (DATA_W)
  ) u_mult (
    .a_i    (a_q),
    .b_i    (b_q),
    .prod_o (prod)
  );

  // Sign-extend everything to the result width; two's-complement wrap then falls out naturally.
  assign a_ext    = RES_W'($signed(a_q));
  assign b_ext    = RES_W'($signed(b_q));
  assign prod_ext = RES_W'($signed(prod));

  // Stage 2 opcode mux; MAC uses the result register itself as the accumulator.
  always_comb begin
    result_d = result_q;
    unique case (op_q)
      OP_ADD:  result_d = a_ext + b_ext;
      OP_MUL:  result_d = prod_ext;
      OP_SUB:  result_d = a_ext - b_ext;
      OP_MAC:  result_d = result_q + prod_ext;
      default: result_d = result_q;
    endcase
  end

  // Stage 2: result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: table-driven vectors through a scoreboard queue,
// plus hand-written reset sequences.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  op_sel;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;

  typedef struct {
    logic [1:0] op;
    int         a;
    int         b;
    int         exp;
  } vec_t;

  typedef struct {
    int exp;
    int due;
    int id;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   next_id = 0;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .op_sel (op_sel),
    .a      (a),
    .b      (b),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Compare every scoreboard entry whose result should be visible by now.
  task automatic drain();
    while (sb.size() > 0 && sb[0].due <= edges) begin
      check($sformatf("op%0d", sb[0].id), int'(result), sb[0].exp);
      void'(sb.pop_front());
    end
  endtask

  task automatic push(input int ev);
    sb.push_back('{exp: ev, due: edges + 2, id: next_id});
    next_id++;
  endtask

  // Drive one operation at the falling edge; it is captured on the next rising edge.
  task automatic step(input logic [1:0] op, input int av, input int bv, input int ev);
    @(negedge clk);
    drain();
    op_sel = op;
    a      = 16'(av);
    b      = 16'(bv);
    push(ev);
  endtask

  task automatic flush();
    for (int i = 0; i < 8 && sb.size() > 0; i++) begin
      @(negedge clk);
      drain();
      op_sel = OP_ADD;
      a      = '0;
      b      = '0;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL flush_timeout: %0d results still pending", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    // Basic function, pipelining, MAC chains, wrap and held-input behaviour.
    vecs.push_back('{OP_ADD, 1234, -34, 1200});
    vecs.push_back('{OP_ADD, 32767, 32767, 65534});
    vecs.push_back('{OP_ADD, -32768, -32768, -65536});
    vecs.push_back('{OP_MUL, -3, 7, -21});
    vecs.push_back('{OP_MUL, 32767, -32768, -1073709056});
    vecs.push_back('{OP_MUL, -32768, -32768, 1073741824});
    vecs.push_back('{OP_ADD, 5, 6, 11});
    vecs.push_back('{OP_MUL, 5, 6, 30});
    vecs.push_back('{OP_SUB, 5, 6, -1});
    vecs.push_back('{OP_MUL, 2, 3, 6});
    vecs.push_back('{OP_MAC, 4, 5, 26});
    vecs.push_back('{OP_MAC, -1, 10, 16});
    vecs.push_back('{OP_MAC, 100, 100, 10016});
    vecs.push_back('{OP_ADD, 1, 1, 2});
    vecs.push_back('{OP_SUB, -32768, 32767, -65535});
    vecs.push_back('{OP_SUB, 32767, -32768, 65535});
    vecs.push_back('{OP_ADD, 1234, -34, 1200});
    vecs.push_back('{OP_ADD, 1234, -34, 1200});
    vecs.push_back('{OP_ADD, 1234, -34, 1200});
    vecs.push_back('{OP_MUL, 0, 0, 0});
    vecs.push_back('{OP_MAC, 2, 3, 6});
    vecs.push_back('{OP_MAC, 2, 3, 12});
    vecs.push_back('{OP_MAC, 2, 3, 18});
    vecs.push_back('{OP_MUL, -32768, -32768, 1073741824});
    vecs.push_back('{OP_MAC, -32768, -32768, int'(32'h8000_0000)});
    vecs.push_back('{OP_MAC, -32768, -32768, -1073741824});
    vecs.push_back('{OP_SUB, 7, 7, 0});

    // Reset held with a live multiply at the inputs: result must stay 0.
    rst    = 1'b0;
    op_sel = OP_MUL;
    a      = 16'd100;
    b      = 16'd200;
    #1 check("rst_initial", int'(result), 0);
    repeat (3) begin
      @(posedge clk);
      #1 check("rst_hold", int'(result), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    push(20000);
    flush();

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end
    flush();

    // Asynchronous reset in the middle of a MAC chain.
    step(OP_MUL, 2, 3, 6);
    step(OP_MAC, 1, 1, 7);
    step(OP_MAC, 1, 1, 8);
    @(negedge clk);
    drain();
    #1 rst = 1'b0;
    #1 check("async_rst_clear", int'(result), 0);
    sb.delete();
    @(posedge clk);
    #1 check("async_rst_hold", int'(result), 0);
    @(negedge clk);
    op_sel = OP_MAC;
    a      = 16'd3;
    b      = 16'd3;
    rst    = 1'b1;
    push(9);
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
